// File: rtl/icache_fill_controller_pkg.sv
// Shared types, default-geometry constants and address-split helpers for the
// I-cache line refill controller.
package icache_fill_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_FILL,
    ST_TAG,
    ST_DONE
  } fill_state_e;

  // Default geometry: 32-bit addresses, 32-byte lines, 64-bit beats, 128 sets.
  localparam int ADDR_WIDTH   = 32;
  localparam int LINE_BYTES   = 32;
  localparam int BEAT_WIDTH   = 64;
  localparam int INDEX_WIDTH  = 7;
  localparam int BEATS        = LINE_BYTES * 8 / BEAT_WIDTH;
  localparam int OFFSET_WIDTH = $clog2(LINE_BYTES);
  localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

  // Helpers work on a 64-bit container so any address width up to 64 fits;
  // callers size-cast the result down to their own field width.
  function automatic logic [63:0] to_line_addr(input logic [63:0] addr, input int offset_w);
    logic [63:0] mask;
    mask = ~((64'd1 << offset_w) - 64'd1);
    return addr & mask;
  endfunction

  function automatic logic [63:0] to_index(input logic [63:0] addr, input int offset_w,
                                           input int index_w);
    logic [63:0] mask;
    mask = (64'd1 << index_w) - 64'd1;
    return (addr >> offset_w) & mask;
  endfunction

  function automatic logic [63:0] to_tag(input logic [63:0] addr, input int tag_shift);
    return addr >> tag_shift;
  endfunction

endpackage

// File: rtl/icache_fill_controller.sv
// I-cache line refill sequencer: latches a fetch miss, issues one line
// request, steers the returned beats into the data array, writes the tag
// last and then reports the line resident to the fetch stage.
module icache_fill_controller #(
  parameter  int ADDR_WIDTH      = 32,
  parameter  int LINE_BYTE_WIDTH = 32,
  parameter  int BEAT_WIDTH      = 64,
  parameter  int INDEX_WIDTH     = 7,
  localparam int BEATS           = LINE_BYTE_WIDTH * 8 / BEAT_WIDTH,
  localparam int BEAT_IDX_W      = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int OFFSET_WIDTH    = $clog2(LINE_BYTE_WIDTH),
  localparam int TAG_WIDTH       = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   missValid,
  input  logic [ADDR_WIDTH-1:0]  missAddr,
  input  logic                   flush,
  output logic                   memReqValid,
  input  logic                   memReqReady,
  output logic [ADDR_WIDTH-1:0]  memReqAddr,
  input  logic                   memRspValid,
  input  logic [BEAT_WIDTH-1:0]  memRspData,
  output logic                   dataWE,
  output logic [INDEX_WIDTH-1:0] dataIndex,
  output logic [BEAT_IDX_W-1:0]  dataBeat,
  output logic [BEAT_WIDTH-1:0]  dataWord,
  output logic                   tagWE,
  output logic [TAG_WIDTH-1:0]   tagValue,
  output logic                   busy,
  output logic                   fillDone
);

  import icache_fill_controller_pkg::*;

  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

  fill_state_e             state_q, state_d;
  logic [BEAT_IDX_W-1:0]   beat_q, beat_d;
  logic                    squashed_q, squashed_d;
  logic [ADDR_WIDTH-1:0]   line_addr_q, line_addr_d;
  logic                    req_valid_q, req_valid_d;
  logic                    tag_we_q, tag_we_d;
  logic                    fill_done_q, fill_done_d;
  logic                    busy_q, busy_d;
  logic                    fill_wr;

  // Next-state, beat counter, squash tracking and registered-output decode.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    squashed_d  = squashed_q;
    line_addr_d = line_addr_q;
    fill_wr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (missValid && !flush) begin
          line_addr_d = ADDR_WIDTH'(to_line_addr(64'(missAddr), OFFSET_WIDTH));
          squashed_d  = 1'b0;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        // Once memory has taken the request it cannot be cancelled, so a
        // simultaneous flush only suppresses the completion pulse.
        if (memReqReady) begin
          state_d = ST_FILL;
          beat_d  = '0;
          if (flush) squashed_d = 1'b1;
        end else if (flush) begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (flush) squashed_d = 1'b1;
        if (memRspValid) begin
          fill_wr = 1'b1;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = ST_TAG;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_TAG: begin
        // The line is still written in full; a late flush only hides fillDone.
        if (flush) squashed_d = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    req_valid_d = (state_d == ST_REQ);
    tag_we_d    = (state_d == ST_TAG);
    fill_done_d = (state_d == ST_DONE) && !squashed_d;
    busy_d      = (state_d != ST_IDLE);
  end

  // Single state register for the FSM, its counter and its registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      squashed_q  <= 1'b0;
      line_addr_q <= '0;
      req_valid_q <= 1'b0;
      tag_we_q    <= 1'b0;
      fill_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      squashed_q  <= squashed_d;
      line_addr_q <= line_addr_d;
      req_valid_q <= req_valid_d;
      tag_we_q    <= tag_we_d;
      fill_done_q <= fill_done_d;
      busy_q      <= busy_d;
    end
  end

  assign memReqValid = req_valid_q;
  assign memReqAddr  = line_addr_q;
  assign dataWE      = fill_wr;
  assign dataBeat    = beat_q;
  assign dataWord    = fill_wr ? memRspData : '0;
  assign dataIndex   = INDEX_WIDTH'(to_index(64'(line_addr_q), OFFSET_WIDTH, INDEX_WIDTH));
  assign tagWE       = tag_we_q;
  assign tagValue    = TAG_WIDTH'(to_tag(64'(line_addr_q), OFFSET_WIDTH + INDEX_WIDTH));
  assign busy        = busy_q;
  assign fillDone    = fill_done_q;

  // Response beats are only legal while a fill is collecting data.
  property p_rsp_only_in_fill;
    @(posedge clk) disable iff (rst) memRspValid |-> (state_q == ST_FILL);
  endproperty
  a_rsp_only_in_fill: assert property (p_rsp_only_in_fill);

endmodule

// File: tb/tb_icache_fill_controller.sv
// Directed, table-driven bench for icache_fill_controller (default geometry).
module tb_icache_fill_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        missValid;
  logic [31:0] missAddr;
  logic        flush;
  logic        memReqValid;
  logic        memReqReady;
  logic [31:0] memReqAddr;
  logic        memRspValid;
  logic [63:0] memRspData;
  logic        dataWE;
  logic [6:0]  dataIndex;
  logic [1:0]  dataBeat;
  logic [63:0] dataWord;
  logic        tagWE;
  logic [19:0] tagValue;
  logic        busy;
  logic        fillDone;

  icache_fill_controller dut (
    .clk(clk), .rst(rst), .missValid(missValid), .missAddr(missAddr), .flush(flush),
    .memReqValid(memReqValid), .memReqReady(memReqReady), .memReqAddr(memReqAddr),
    .memRspValid(memRspValid), .memRspData(memRspData), .dataWE(dataWE),
    .dataIndex(dataIndex), .dataBeat(dataBeat), .dataWord(dataWord), .tagWE(tagWE),
    .tagValue(tagValue), .busy(busy), .fillDone(fillDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mv;
    logic [31:0] ma;
    logic        fl;
    logic        rdy;
    logic        rv;
    logic [63:0] rd;
    logic        e_rv;
    logic [31:0] e_ra;
    logic        e_we;
    logic [1:0]  e_beat;
    logic [63:0] e_word;
    logic [6:0]  e_idx;
    logic        e_twe;
    logic [19:0] e_tag;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  typedef struct packed {
    logic        rv;
    logic [31:0] ra;
    logic        we;
    logic [1:0]  beat;
    logic [63:0] word;
    logic [6:0]  idx;
    logic        twe;
    logic [19:0] tag;
    logic        busy;
    logic        done;
  } obs_t;

  vec_t        vecs[$];
  int          errors = 0;
  int          checks = 0;
  logic        bm_v   = 1'b0;   // missValid driven during busy rows
  logic [31:0] bm_a   = '0;

  task automatic add(input logic mv, input logic [31:0] ma, input logic fl, input logic rdy,
                     input logic rv, input logic [63:0] rd, input logic e_rv,
                     input logic [31:0] e_ra, input logic e_we, input logic [1:0] e_beat,
                     input logic [63:0] e_word, input logic [6:0] e_idx, input logic e_twe,
                     input logic [19:0] e_tag, input logic e_busy, input logic e_done);
    vec_t v;
    v.mv = mv; v.ma = ma; v.fl = fl; v.rdy = rdy; v.rv = rv; v.rd = rd;
    v.e_rv = e_rv; v.e_ra = e_ra; v.e_we = e_we; v.e_beat = e_beat; v.e_word = e_word;
    v.e_idx = e_idx; v.e_twe = e_twe; v.e_tag = e_tag; v.e_busy = e_busy; v.e_done = e_done;
    vecs.push_back(v);
  endtask

  // Row builders: each row is one clock cycle, expected outputs are those seen
  // during that cycle with the row's inputs applied.
  task automatic t_idle(input logic mv, input logic [31:0] ma, input logic fl);
    add(mv, ma, fl, 0, 0, '0, 0, '0, 0, '0, '0, '0, 0, '0, 0, 0);
  endtask
  task automatic t_req(input logic rdy, input logic fl, input logic [31:0] ra);
    add(bm_v, bm_a, fl, rdy, 0, '0, 1, ra, 0, '0, '0, '0, 0, '0, 1, 0);
  endtask
  task automatic t_beat(input logic [1:0] k, input logic [63:0] d, input logic fl,
                        input logic [6:0] idx);
    add(bm_v, bm_a, fl, 0, 1, d, 0, '0, 1, k, d, idx, 0, '0, 1, 0);
  endtask
  task automatic t_gap(input logic fl);
    add(bm_v, bm_a, fl, 0, 0, '0, 0, '0, 0, '0, '0, '0, 0, '0, 1, 0);
  endtask
  task automatic t_tag(input logic [6:0] idx, input logic [19:0] tag);
    add(bm_v, bm_a, 0, 0, 0, '0, 0, '0, 0, '0, '0, idx, 1, tag, 1, 0);
  endtask
  task automatic t_done(input logic done);
    add(bm_v, bm_a, 0, 0, 0, '0, 0, '0, 0, '0, '0, '0, 0, '0, 1, done);
  endtask

  task automatic run_rows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      vec_t v;
      obs_t act, exp_o;
      v = vecs[i];
      @(negedge clk);
      missValid   = v.mv;
      missAddr    = v.ma;
      flush       = v.fl;
      memReqReady = v.rdy;
      memRspValid = v.rv;
      memRspData  = v.rd;
      #1;
      act.rv   = memReqValid;
      act.ra   = v.e_rv ? memReqAddr : '0;
      act.we   = dataWE;
      act.beat = v.e_we ? dataBeat : '0;
      act.word = v.e_we ? dataWord : '0;
      act.idx  = (v.e_we || v.e_twe) ? dataIndex : '0;
      act.twe  = tagWE;
      act.tag  = v.e_twe ? tagValue : '0;
      act.busy = busy;
      act.done = fillDone;
      exp_o = '{v.e_rv, v.e_ra, v.e_we, v.e_beat, v.e_word, v.e_idx, v.e_twe, v.e_tag,
                v.e_busy, v.e_done};
      checks++;
      if (act !== exp_o) begin
        errors++;
        $display("FAIL row%0d outputs: got %h expected %h", i, act, exp_o);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [168:0] all;
    all = {memReqValid, memReqAddr, dataWE, dataBeat, dataWord, dataIndex, tagWE, tagValue,
           busy, fillDone};
    checks++;
    if (all !== '0) begin
      errors++;
      $display("FAIL %s: outputs got %h expected all zero", name, all);
    end
  endtask

  int a_first, a_last, b_first, e_last;

  initial begin
    rst = 1'b1; missValid = 0; missAddr = '0; flush = 0; memReqReady = 0;
    memRspValid = 0; memRspData = '0;

    // A: basic fill, 0x1234 -> line 0x1220, index 0x11, tag 0x00001.
    a_first = vecs.size();
    t_idle(1, 32'h0000_1234, 0);
    t_req(1, 0, 32'h0000_1220);
    t_beat(0, 64'hD0D0_0000_0000_0000, 0, 7'h11);
    t_beat(1, 64'hD1D1_0000_0000_0001, 0, 7'h11);
    t_beat(2, 64'hD2D2_0000_0000_0002, 0, 7'h11);
    t_beat(3, 64'hD3D3_0000_0000_0003, 0, 7'h11);
    t_tag(7'h11, 20'h00001);
    t_done(1);
    t_idle(0, '0, 0);
    a_last = vecs.size() - 1;

    // B: 3 cycles of backpressure, one gap between beats 1 and 2.
    b_first = vecs.size();
    t_idle(1, 32'h0000_5678, 0);
    t_req(0, 0, 32'h0000_5660);
    t_req(0, 0, 32'h0000_5660);
    t_req(0, 0, 32'h0000_5660);
    t_req(1, 0, 32'h0000_5660);
    t_beat(0, 64'h0123_4567_89AB_CDEF, 0, 7'h33);
    t_beat(1, 64'hFEDC_BA98_7654_3210, 0, 7'h33);
    t_gap(0);
    t_beat(2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 7'h33);
    t_beat(3, 64'h0000_0000_0000_0001, 0, 7'h33);
    t_tag(7'h33, 20'h00005);
    t_done(1);
    t_idle(0, '0, 0);

    // C: flush in REQ before ready, then a miss with flush is not accepted.
    t_idle(1, 32'h0000_9ABC, 0);
    t_req(0, 1, 32'h0000_9AA0);
    t_idle(0, '0, 0);
    t_idle(0, '0, 0);
    t_idle(1, 32'h0000_4444, 1);
    t_idle(0, '0, 0);

    // D: flush during FILL after beat 1; line still fully written, no fillDone.
    t_idle(1, 32'h0000_0040, 0);
    t_req(1, 0, 32'h0000_0040);
    t_beat(0, 64'hAAAA_0000_0000_0000, 0, 7'h02);
    t_beat(1, 64'hAAAA_0000_0000_0001, 0, 7'h02);
    t_gap(1);
    t_beat(2, 64'hAAAA_0000_0000_0002, 0, 7'h02);
    t_beat(3, 64'hAAAA_0000_0000_0003, 0, 7'h02);
    t_tag(7'h02, 20'h00000);
    t_done(0);
    t_idle(0, '0, 0);

    // E: miss to 0x2000 presented while busy is ignored, then taken after DONE.
    t_idle(1, 32'h0000_1000, 0);
    bm_v = 1'b1; bm_a = 32'h0000_2000;
    t_req(0, 0, 32'h0000_1000);
    t_req(1, 0, 32'h0000_1000);
    t_beat(0, 64'h1, 0, 7'h00);
    t_beat(1, 64'h2, 0, 7'h00);
    t_beat(2, 64'h3, 0, 7'h00);
    t_beat(3, 64'h4, 0, 7'h00);
    t_tag(7'h00, 20'h00001);
    t_done(1);
    bm_v = 1'b0; bm_a = '0;
    t_idle(1, 32'h0000_2000, 0);
    t_req(0, 0, 32'h0000_2000);
    t_req(1, 0, 32'h0000_2000);
    t_beat(0, 64'h5, 0, 7'h00);
    t_beat(1, 64'h6, 0, 7'h00);
    t_beat(2, 64'h7, 0, 7'h00);
    t_beat(3, 64'h8, 0, 7'h00);
    t_tag(7'h00, 20'h00002);
    t_done(1);
    t_idle(0, '0, 0);
    e_last = vecs.size() - 1;

    #1;
    check_all_zero("reset_state");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_rows(a_first, e_last);

    // Asynchronous reset mid-FILL, after beat 2 has been written.
    run_rows(a_first, a_first + 4);
    @(negedge clk);
    memRspValid = 1'b1;
    memRspData  = 64'hD3D3_0000_0000_0003;
    #1;
    checks++;
    if (!(dataWE === 1'b1 && dataBeat === 2'd3 && dataWord === 64'hD3D3_0000_0000_0003)) begin
      errors++;
      $display("FAIL pre_reset_beat3: got we=%b beat=%0d word=%h expected we=1 beat=3 word=d3d3000000000003",
               dataWE, dataBeat, dataWord);
    end
    #1 rst = 1'b1;
    #1;
    check_all_zero("async_reset_mid_fill");
    memRspValid = 1'b0;
    memRspData  = '0;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset_released_idle");

    // Fresh fill after reset must restart at beat 0.
    run_rows(a_first, a_last);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_fill_controller.md
Name: icache_fill_controller

Overview:
- Sequences I-cache line refills after a fetch-stage miss.
- Takes the miss address from the fetch stage, issues one line request to the memory port, and counts the returned beats into the data array.
- Writes the tag last, then tells the fetch stage the line is resident so it can release its stall.
- Sits between the fetch stage, the I-cache arrays, and the memory request/response port.

Parameters:
- ADDR_WIDTH, 32, physical address width.
- LINE_BYTE_WIDTH, 32, bytes per cache line.
- BEAT_WIDTH, 64, memory response data width in bits.
- INDEX_WIDTH, 7, cache set-index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- missValid  in  1  fetch stage reports an I-cache miss this cycle.
- missAddr  in  ADDR_WIDTH  physical address of the missing fetch.
- flush  in  1  fetch-stage clear; the pending miss is no longer wanted.
- memReqValid  out  1  line request valid.
- memReqReady  in  1  memory accepts the request.
- memReqAddr  out  ADDR_WIDTH  line-aligned request address.
- memRspValid  in  1  one response beat valid.
- memRspData  in  BEAT_WIDTH  response beat data.
- dataWE  out  1  data-array write enable.
- dataIndex  out  INDEX_WIDTH  set index for data and tag writes.
- dataBeat  out  log2(BEATS)  beat slot within the line.
- dataWord  out  BEAT_WIDTH  data to write.
- tagWE  out  1  tag-array write enable; sets the valid bit.
- tagValue  out  TAG_WIDTH  tag to write.
- busy  out  1  a fill is in progress.
- fillDone  out  1  one-cycle pulse: the line for the latched miss is resident.

Behaviour:
- Derived constants:
  - BEATS = LINE_BYTE_WIDTH*8/BEAT_WIDTH (default 4).
  - OFFSET_WIDTH = log2(LINE_BYTE_WIDTH).
  - TAG_WIDTH = ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH.
- Reset (asynchronous):
  - state=IDLE; beat counter=0; squashed=0.
  - All outputs 0: memReqValid, dataWE, tagWE, busy, fillDone, and all address/data outputs.
- FSM states: IDLE, REQ, FILL, TAG, DONE.
- IDLE:
  - If missValid && !flush: latch lineAddr = missAddr with the low OFFSET_WIDTH bits zeroed; clear squashed; go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - memReqValid=1 and memReqAddr=lineAddr, held stable until memReqReady.
  - flush while !memReqReady: drop the request and return to IDLE with no memory traffic.
  - memReqReady: go to FILL; beat counter=0.
  - flush in the same cycle as memReqReady: the request is committed, so go to FILL with squashed=1.
- FILL:
  - Each memRspValid cycle: dataWE=1 combinationally, dataBeat=counter, dataWord=memRspData, dataIndex=lineAddr index field; counter increments.
  - Response gaps are allowed and stall the counter.
  - After the beat where counter==BEATS-1 is written, go to TAG.
  - flush during FILL sets squashed=1. The fill still completes, because memory cannot cancel and the line data is valid.
- TAG: tagWE=1 for one cycle with tagValue = lineAddr tag field; go to DONE.
  - The tag is written after all data, so a partially filled line never hits.
- DONE: fillDone = !squashed for one cycle; go to IDLE.
- busy=1 in every state except IDLE.
- missValid while busy is ignored; the fetch stage is stalled and re-presents the miss if it is still needed.
- memRspValid outside FILL is a protocol error and is ignored (checked by an assertion).
- Latency, zero-wait memory with ready in the first REQ cycle and back-to-back beats: miss accepted in cycle 0; REQ cycle 1; beats cycles 2..5; TAG cycle 6; fillDone cycle 7.
- A new miss can be accepted in the cycle after DONE.

Decomposition:
- Shared package ICacheFillTypes holds:
  - FillState enum (IDLE, REQ, FILL, TAG, DONE).
  - Derived constants BEATS, OFFSET_WIDTH, TAG_WIDTH.
  - Helpers ToLineAddr, ToIndex, ToTag.
- No sub-module is needed. The beat counter is inline in the FSM module.

Test Plan:
- Basic fill: missAddr=0x0000_1234, ready immediately, 4 back-to-back beats D0..D3 -> memReqAddr=0x0000_1220; dataWE at beats 0..3 with dataIndex=0x11; tagWE with tagValue=0x00001; fillDone pulses in cycle 7.
- Backpressure and gaps: memReqReady held low 3 cycles, one idle cycle between beat 1 and beat 2 -> memReqValid and memReqAddr stable for 4 cycles; beats land in slots 0..3 in order; fillDone arrives 4 cycles later than in the basic case.
- Flush in REQ before ready -> return to IDLE; no further memReqValid; busy=0 next cycle; no dataWE, tagWE or fillDone.
- Flush during FILL after beat 1 -> all 4 beats and the tag are still written; fillDone stays 0; busy drops after DONE.
- missValid pulsed while busy with address 0x2000 -> ignored; only the original line is requested; the next miss after DONE is accepted normally.
- Asynchronous reset asserted mid-FILL (after beat 2) -> all outputs 0 immediately with no clock edge; state IDLE; the following miss starts a fresh fill with beat counter 0.
